// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive parser: packet types,
// ethertypes, FSM states and the byte offsets of the parsed ARP fields.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    PKT_NONE = 2'd0,
    PKT_ARP  = 2'd1,
    PKT_IPV4 = 2'd2,
    PKT_RSVD = 2'd3
  } pkt_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ARP,
    ST_SKIP,
    ST_END
  } rx_state_e;

  localparam logic [15:0] ETYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

  // Byte offsets from the first destination-MAC byte.
  localparam logic [5:0] DST_LAST_OFF  = 6'd5;
  localparam logic [5:0] SRC_LAST_OFF  = 6'd11;
  localparam logic [5:0] HDR_LAST_OFF  = 6'd13;
  localparam logic [5:0] ARP_HTYPE_OFF = 6'd14;
  localparam logic [5:0] ARP_PTYPE_OFF = 6'd16;
  localparam logic [5:0] ARP_HLEN_OFF  = 6'd18;
  localparam logic [5:0] ARP_PLEN_OFF  = 6'd19;
  localparam logic [5:0] ARP_OPER_OFF  = 6'd20;
  localparam logic [5:0] ARP_SHA_OFF   = 6'd22;
  localparam logic [5:0] ARP_SPA_OFF   = 6'd28;
  localparam logic [5:0] ARP_THA_OFF   = 6'd32;
  localparam logic [5:0] ARP_TPA_OFF   = 6'd38;
  localparam logic [5:0] ARP_LAST_OFF  = 6'd41;

  localparam logic [5:0] IPV4_MIN_LEN  = 6'd14;
  localparam logic [5:0] ARP_MIN_LEN   = 6'd42;

  // Fixed ARP header bytes are checked as they arrive, so no HTYPE/PTYPE/
  // HLEN/PLEN shadow is needed; OPER must be 0x0001 or 0x0002.
  function automatic logic arp_hdr_byte_ok(input logic [5:0] idx, input logic [7:0] b);
    case (idx)
      ARP_HTYPE_OFF:         return b == 8'h00;
      ARP_HTYPE_OFF + 6'd1:  return b == 8'h01;
      ARP_PTYPE_OFF:         return b == 8'h08;
      ARP_PTYPE_OFF + 6'd1:  return b == 8'h00;
      ARP_HLEN_OFF:          return b == 8'd6;
      ARP_PLEN_OFF:          return b == 8'd4;
      ARP_OPER_OFF:          return b == 8'h00;
      ARP_OPER_OFF + 6'd1:   return (b == 8'h01) || (b == 8'h02);
      default:               return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/eth_rx_parser.sv
// Byte-serial Ethernet receive parser: captures MACs, classifies ARP/IPv4 and
// commits validated ARP fields to stable output registers at end of frame.
module eth_rx_parser
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx_dv,
  input  logic        i_rx_en,
  input  logic [7:0]  i_rx_data,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [1:0]  o_operation,
  output logic [47:0] o_SHA,
  output logic [47:0] o_THA,
  output logic [31:0] o_SPA,
  output logic [31:0] o_TPA,
  output logic [1:0]  o_packet_type,
  output logic        o_pkt_valid,
  output logic [15:0] o_drop_cnt
);

  rx_state_e   state, state_nx;
  logic        acc, take, enter_end, commit_arp, commit_ip;
  logic        armed, bad;
  logic [5:0]  cnt;
  logic [15:0] etype;
  logic [47:0] dst_sh, src_sh, sha_sh, tha_sh;
  logic [31:0] spa_sh, tpa_sh;
  logic [1:0]  oper_sh;

  assign acc = i_rx_dv & i_rx_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    unique case (state)
      // armed stays low after a reset until dv has been seen low once
      ST_IDLE: if (acc && armed) begin
        take     = 1'b1;
        state_nx = ST_HDR;
      end
      ST_HDR: begin
        if (!i_rx_dv) state_nx = ST_END;
        else if (acc) begin
          take = 1'b1;
          if (cnt == HDR_LAST_OFF)
            state_nx = ({etype[7:0], i_rx_data} == ETYPE_ARP) ? ST_ARP : ST_SKIP;
        end
      end
      ST_ARP: begin
        if (!i_rx_dv) state_nx = ST_END;
        else if (acc) begin
          take = 1'b1;
          if (cnt == ARP_LAST_OFF) state_nx = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (!i_rx_dv) state_nx = ST_END;
        else if (acc) take = 1'b1;
      end
      ST_END:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Commit is decided on the edge that moves into END, so the outputs and
  // the pulse become visible together during the END cycle.
  always_comb begin
    enter_end  = (state != ST_END) && (state_nx == ST_END);
    commit_arp = enter_end && (etype == ETYPE_ARP) && (cnt >= ARP_MIN_LEN) && !bad;
    commit_ip  = enter_end && (etype == ETYPE_IPV4) && (cnt >= IPV4_MIN_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      bad     <= 1'b0;
      cnt     <= '0;
      etype   <= '0;
      dst_sh  <= '0;
      src_sh  <= '0;
      sha_sh  <= '0;
      tha_sh  <= '0;
      spa_sh  <= '0;
      tpa_sh  <= '0;
      oper_sh <= '0;
    end else begin
      if (!i_rx_dv) armed <= 1'b1;
      if (state == ST_END) cnt <= '0;
      else if (take) begin
        cnt <= (cnt == 6'd63) ? cnt : cnt + 6'd1;
        if (state == ST_IDLE) bad <= 1'b0;
        if (cnt <= DST_LAST_OFF)      dst_sh <= {dst_sh[39:0], i_rx_data};
        else if (cnt <= SRC_LAST_OFF) src_sh <= {src_sh[39:0], i_rx_data};
        else if (cnt <= HDR_LAST_OFF) etype  <= {etype[7:0], i_rx_data};
        else if (state == ST_ARP) begin
          if (!arp_hdr_byte_ok(cnt, i_rx_data)) bad <= 1'b1;
          if (cnt == ARP_OPER_OFF + 6'd1) oper_sh <= i_rx_data[1:0];
          if (cnt >= ARP_SHA_OFF && cnt < ARP_SPA_OFF)
            sha_sh <= {sha_sh[39:0], i_rx_data};
          if (cnt >= ARP_SPA_OFF && cnt < ARP_THA_OFF)
            spa_sh <= {spa_sh[23:0], i_rx_data};
          if (cnt >= ARP_THA_OFF && cnt < ARP_TPA_OFF)
            tha_sh <= {tha_sh[39:0], i_rx_data};
          if (cnt >= ARP_TPA_OFF)
            tpa_sh <= {tpa_sh[23:0], i_rx_data};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dst_mac     <= '0;
      o_src_mac     <= '0;
      o_operation   <= '0;
      o_SHA         <= '0;
      o_THA         <= '0;
      o_SPA         <= '0;
      o_TPA         <= '0;
      o_packet_type <= PKT_NONE;
      o_pkt_valid   <= 1'b0;
      o_drop_cnt    <= '0;
    end else begin
      o_pkt_valid <= commit_arp | commit_ip;
      if (commit_arp | commit_ip) begin
        o_dst_mac <= dst_sh;
        o_src_mac <= src_sh;
      end
      if (commit_arp) begin
        o_packet_type <= PKT_ARP;
        o_operation   <= oper_sh;
        o_SHA         <= sha_sh;
        o_THA         <= tha_sh;
        o_SPA         <= spa_sh;
        o_TPA         <= tpa_sh;
      end
      if (commit_ip) o_packet_type <= PKT_IPV4;
      if (enter_end && !(commit_arp | commit_ip) && (o_drop_cnt != 16'hFFFF))
        o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_parser.sv
// Directed bench for eth_rx_parser: ARP/IPv4 commits, malformed and
// truncated drops, byte-strobe gaps and reset in the middle of a frame.
module tb_eth_rx_parser;
  import eth_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rx_dv, i_rx_en;
  logic [7:0]  i_rx_data;
  logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
  logic [31:0] o_SPA, o_TPA;
  logic [1:0]  o_operation, o_packet_type;
  logic        o_pkt_valid;
  logic [15:0] o_drop_cnt;

  int passed = 0;
  int total  = 0;
  int pulses = 0;
  int p0;
  logic [7:0] fb [0:63];

  eth_rx_parser dut (
    .clk(clk), .rst_n(rst_n), .i_rx_dv(i_rx_dv), .i_rx_en(i_rx_en),
    .i_rx_data(i_rx_data), .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac),
    .o_operation(o_operation), .o_SHA(o_SHA), .o_THA(o_THA), .o_SPA(o_SPA),
    .o_TPA(o_TPA), .o_packet_type(o_packet_type), .o_pkt_valid(o_pkt_valid),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_pkt_valid) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic build_arp(input logic [47:0] dst, input logic [47:0] src,
                           input logic [15:0] oper, input logic [47:0] sha,
                           input logic [31:0] spa, input logic [47:0] tha,
                           input logic [31:0] tpa, input logic [7:0] plen);
    for (int k = 0; k < 64; k++) fb[k] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      fb[k]      = dst[47-8*k -: 8];
      fb[6+k]    = src[47-8*k -: 8];
      fb[22+k]   = sha[47-8*k -: 8];
      fb[32+k]   = tha[47-8*k -: 8];
    end
    for (int k = 0; k < 4; k++) begin
      fb[28+k] = spa[31-8*k -: 8];
      fb[38+k] = tpa[31-8*k -: 8];
    end
    fb[12] = 8'h08; fb[13] = 8'h06; fb[14] = 8'h00; fb[15] = 8'h01;
    fb[16] = 8'h08; fb[17] = 8'h00; fb[18] = 8'd6;  fb[19] = plen;
    fb[20] = oper[15:8]; fb[21] = oper[7:0];
  endtask

  // Sends fb[0:len-1]; gap_max>0 inserts random en-low cycles; a reset
  // pulse is applied before byte rst_at when rst_at < len.
  task automatic send_frame(input int len, input int gap_max, input int rst_at);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        i_rx_en = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
      if (gap_max > 0) begin
        int g = $urandom_range(gap_max, 0);
        for (int j = 0; j < g; j++) begin
          i_rx_dv = 1'b1; i_rx_en = 1'b0; i_rx_data = 8'hEE;
          @(posedge clk); #1;
        end
      end
      i_rx_dv = 1'b1; i_rx_en = 1'b1; i_rx_data = fb[i];
      @(posedge clk); #1;
    end
    i_rx_dv = 1'b0; i_rx_en = 1'b0; i_rx_data = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; i_rx_dv = 1'b0; i_rx_en = 1'b0; i_rx_data = 8'h00;
    idle(3);
    chk("rst_valid", 64'(o_pkt_valid), 64'd0);
    chk("rst_type",  64'(o_packet_type), 64'd0);
    chk("rst_drop",  64'(o_drop_cnt), 64'd0);
    chk("rst_dst",   64'(o_dst_mac), 64'd0);
    rst_n = 1'b1;
    idle(3);

    // ARP request, 60 bytes
    build_arp(48'hFFFFFFFFFFFF, 48'h001122334455, 16'd1, 48'h001122334455,
              32'hC0A80001, 48'h000000000000, 32'hC0A80002, 8'd4);
    p0 = pulses;
    send_frame(60, 0, 99);
    idle(3);
    chk("arp1_pulses", 64'(pulses - p0), 64'd1);
    chk("arp1_dst",  64'(o_dst_mac), 64'hFFFFFFFFFFFF);
    chk("arp1_src",  64'(o_src_mac), 64'h001122334455);
    chk("arp1_op",   64'(o_operation), 64'd1);
    chk("arp1_type", 64'(o_packet_type), 64'd1);
    chk("arp1_sha",  64'(o_SHA), 64'h001122334455);
    chk("arp1_spa",  64'(o_SPA), 64'hC0A80001);
    chk("arp1_tha",  64'(o_THA), 64'h0);
    chk("arp1_tpa",  64'(o_TPA), 64'hC0A80002);
    chk("arp1_drop", 64'(o_drop_cnt), 64'd0);

    // PLEN=6 -> dropped, outputs unchanged
    build_arp(48'h0A0A0A0A0A0A, 48'h0B0B0B0B0B0B, 16'd1, 48'h0B0B0B0B0B0B,
              32'hC0A80063, 48'h0, 32'hC0A80064, 8'd6);
    p0 = pulses;
    send_frame(60, 0, 99);
    idle(3);
    chk("plen_pulses", 64'(pulses - p0), 64'd0);
    chk("plen_drop", 64'(o_drop_cnt), 64'd1);
    chk("plen_dst",  64'(o_dst_mac), 64'hFFFFFFFFFFFF);
    chk("plen_spa",  64'(o_SPA), 64'hC0A80001);

    // ARP truncated at byte 30
    build_arp(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'd2, 48'h0D0D0D0D0D0D,
              32'hC0A800AA, 48'h0, 32'hC0A800BB, 8'd4);
    p0 = pulses;
    send_frame(30, 0, 99);
    @(posedge clk); #1;
    chk("trunc_idle", 64'(dut.state), 64'(ST_IDLE));
    idle(2);
    chk("trunc_pulses", 64'(pulses - p0), 64'd0);
    chk("trunc_drop", 64'(o_drop_cnt), 64'd2);
    chk("trunc_src",  64'(o_src_mac), 64'h001122334455);

    // IPv4 frame after ARP commit
    for (int k = 0; k < 64; k++) fb[k] = 8'(k);
    for (int k = 0; k < 6; k++) begin
      fb[k] = 8'h0A + 8'(k); fb[6+k] = 8'h10 * 8'(k + 1);
    end
    fb[12] = 8'h08; fb[13] = 8'h00;
    p0 = pulses;
    send_frame(60, 0, 99);
    idle(3);
    chk("ip_pulses", 64'(pulses - p0), 64'd1);
    chk("ip_type", 64'(o_packet_type), 64'd2);
    chk("ip_dst",  64'(o_dst_mac), 64'h0A0B0C0D0E0F);
    chk("ip_src",  64'(o_src_mac), 64'h102030405060);
    chk("ip_spa",  64'(o_SPA), 64'hC0A80001);
    chk("ip_op",   64'(o_operation), 64'd1);
    chk("ip_drop", 64'(o_drop_cnt), 64'd2);

    // ARP reply with random byte-strobe gaps
    build_arp(48'h001122334455, 48'hAABBCCDDEEFF, 16'd2, 48'hAABBCCDDEEFF,
              32'hC0A8000A, 48'h001122334455, 32'hC0A8000B, 8'd4);
    p0 = pulses;
    send_frame(60, 3, 99);
    idle(3);
    chk("gap_pulses", 64'(pulses - p0), 64'd1);
    chk("gap_type", 64'(o_packet_type), 64'd1);
    chk("gap_op",   64'(o_operation), 64'd2);
    chk("gap_dst",  64'(o_dst_mac), 64'h001122334455);
    chk("gap_src",  64'(o_src_mac), 64'hAABBCCDDEEFF);
    chk("gap_sha",  64'(o_SHA), 64'hAABBCCDDEEFF);
    chk("gap_spa",  64'(o_SPA), 64'hC0A8000A);
    chk("gap_tha",  64'(o_THA), 64'h001122334455);
    chk("gap_tpa",  64'(o_TPA), 64'hC0A8000B);

    // reset at byte 20, released mid-frame: frame ignored
    p0 = pulses;
    send_frame(60, 0, 20);
    idle(3);
    chk("mrst_pulses", 64'(pulses - p0), 64'd0);
    chk("mrst_dst",  64'(o_dst_mac), 64'd0);
    chk("mrst_spa",  64'(o_SPA), 64'd0);
    chk("mrst_type", 64'(o_packet_type), 64'd0);
    chk("mrst_op",   64'(o_operation), 64'd0);
    chk("mrst_drop", 64'(o_drop_cnt), 64'd0);

    build_arp(48'hFFFFFFFFFFFF, 48'h001122334455, 16'd1, 48'h001122334455,
              32'hC0A80001, 48'h000000000000, 32'hC0A80002, 8'd4);
    p0 = pulses;
    send_frame(60, 0, 99);
    idle(3);
    chk("post_pulses", 64'(pulses - p0), 64'd1);
    chk("post_type", 64'(o_packet_type), 64'd1);
    chk("post_src",  64'(o_src_mac), 64'h001122334455);
    chk("post_tpa",  64'(o_TPA), 64'hC0A80002);
    chk("post_drop", 64'(o_drop_cnt), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
